// File: rtl/text_row_fetcher_if.sv
// VRAM read port between the row fetcher (master) and the shared VRAM (slave).
interface text_row_fetcher_if;
  logic [10:0] vram_addr;
  logic        vram_en;
  logic [31:0] vram_rdata;

  modport master (output vram_addr, output vram_en, input vram_rdata);
  modport slave  (input vram_addr, input vram_en, output vram_rdata);
endinterface

// File: rtl/text_row_fetcher.sv
// Character-row line buffer for the text-mode color mapper: refills one row of
// VRAM during horizontal blanking and serves the current two-cell word per pixel.
module text_row_fetcher #(
  parameter int WORDS_PER_ROW = 40,
  parameter int ROWS          = 30,
  parameter int READ_LATENCY  = 2,
  parameter int H_ACTIVE      = 640,
  parameter int H_TOTAL       = 800,
  parameter int V_ACTIVE      = 480,
  parameter int V_TOTAL       = 525
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  text_row_fetcher_if.master vram,
  output logic [31:0]        cp_word,
  output logic               fetch_busy,
  output logic               underrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [5:0] LAST_IDX = 6'(WORDS_PER_ROW - 1);

  logic [1:0]              state_r;
  logic [10:0]             addr_r;
  logic                    en_r;
  logic [5:0]              issue_idx_r;
  logic                    busy_r;
  logic                    underrun_r;
  logic                    trig_line_r;
  logic [31:0]             line_buf_r [WORDS_PER_ROW];
  logic [READ_LATENCY-1:0] pipe_valid_r;
  logic [5:0]              pipe_idx_r [READ_LATENCY];

  logic                    trigger_s;
  logic [5:0]              row_s;
  logic [10:0]             base_s;
  logic                    drain_done_s;

  // Row-fetch trigger decode at the first blanking pixel of a line
  always_comb begin
    trigger_s = 1'b0;
    row_s     = 6'd0;
    if (DrawX == 10'(H_ACTIVE)) begin
      if (DrawY == 10'(V_TOTAL - 1)) begin
        trigger_s = 1'b1;
        row_s     = 6'd0;
      end else if ((DrawY < 10'(V_ACTIVE)) && (DrawY[3:0] == 4'hF) &&
                   (({1'b0, DrawY[9:4]} + 7'd1) < 7'(ROWS))) begin
        trigger_s = 1'b1;
        row_s     = DrawY[9:4] + 6'd1;
      end else begin
        trigger_s = 1'b0;
        row_s     = 6'd0;
      end
    end else begin
      trigger_s = 1'b0;
      row_s     = 6'd0;
    end
  end

  assign base_s = 11'(row_s) * 11'(WORDS_PER_ROW);

  // Drain ends once nothing is left behind the output stage of the return pipe
  always_comb begin
    drain_done_s = 1'b1;
    for (int k = 0; k < READ_LATENCY - 1; k++) begin
      drain_done_s = drain_done_s & ~pipe_valid_r[k];
    end
  end

  // Fetch state machine: one read per cycle, then wait for returns
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      addr_r      <= 11'd0;
      en_r        <= 1'b0;
      issue_idx_r <= 6'd0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (trigger_s) begin
            state_r     <= ST_ISSUE;
            addr_r      <= base_s;
            en_r        <= 1'b1;
            issue_idx_r <= 6'd0;
            busy_r      <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (issue_idx_r == LAST_IDX) begin
            state_r <= ST_DRAIN;
            en_r    <= 1'b0;
          end else begin
            addr_r      <= addr_r + 11'd1;
            issue_idx_r <= issue_idx_r + 6'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_done_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          en_r    <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky underrun: the fetch started on this line outlived the line
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_r  <= 1'b0;
      trig_line_r <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && trigger_s) begin
        trig_line_r <= 1'b1;
      end else if (DrawX == 10'(H_TOTAL - 1)) begin
        trig_line_r <= 1'b0;
      end
      if ((DrawX == 10'(H_TOTAL - 1)) && trig_line_r && (state_r != ST_IDLE)) begin
        underrun_r <= 1'b1;
      end
    end
  end

  // Return pipe tracks each issued word index until its data arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid_r <= {READ_LATENCY{1'b0}};
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_idx_r[k] <= 6'd0;
      end
      for (int w = 0; w < WORDS_PER_ROW; w++) begin
        line_buf_r[w] <= 32'd0;
      end
    end else begin
      pipe_valid_r[0] <= en_r;
      pipe_idx_r[0]   <= issue_idx_r;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_valid_r[k] <= pipe_valid_r[k-1];
        pipe_idx_r[k]   <= pipe_idx_r[k-1];
      end
      if (pipe_valid_r[READ_LATENCY-1]) begin
        line_buf_r[pipe_idx_r[READ_LATENCY-1]] <= vram.vram_rdata;
      end
    end
  end

  // Zero-latency word select for the current pixel; blanking reads as zero
  always_comb begin
    cp_word = 32'd0;
    if ((DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE)) &&
        (DrawX[9:4] < 6'(WORDS_PER_ROW))) begin
      cp_word = line_buf_r[DrawX[9:4]];
    end else begin
      cp_word = 32'd0;
    end
  end

  assign vram.vram_addr = addr_r;
  assign vram.vram_en   = en_r;
  assign fetch_busy     = busy_r;
  assign underrun       = underrun_r;

endmodule

// File: tb/tb_text_row_fetcher.sv
// Bench for text_row_fetcher: timing-rule reference model, vector table,
// directed corner sequences and randomized scanlines.
module tb_text_row_fetcher;
  localparam int L  = 2;
  localparam int LU = 130;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic [31:0] cp_word, cp_word_u;
  logic        fetch_busy, fetch_busy_u, underrun, underrun_u;

  text_row_fetcher_if vif ();
  text_row_fetcher_if vif_u ();

  text_row_fetcher #(.READ_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .vram(vif),
    .cp_word(cp_word), .fetch_busy(fetch_busy), .underrun(underrun));

  text_row_fetcher #(.READ_LATENCY(LU)) dut_u (
    .clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .vram(vif_u),
    .cp_word(cp_word_u), .fetch_busy(fetch_busy_u), .underrun(underrun_u));

  always #5 clk = ~clk;

  // VRAM models: word at addr holds A000_0000+addr, returned L cycles after issue
  int          vcyc = 0, vcyc_u = 0;
  logic [31:0] ret_q [int];
  logic [31:0] ret_u [int];

  always @(negedge clk) begin
    if (vif.vram_en === 1'b1) ret_q[vcyc + L] = 32'hA000_0000 + {21'd0, vif.vram_addr};
    if (ret_q.exists(vcyc)) begin
      vif.vram_rdata = ret_q[vcyc];
      ret_q.delete(vcyc);
    end else begin
      vif.vram_rdata = $urandom;
    end
    vcyc++;
  end

  always @(negedge clk) begin
    if (vif_u.vram_en === 1'b1) ret_u[vcyc_u + LU] = 32'hA000_0000 + {21'd0, vif_u.vram_addr};
    if (ret_u.exists(vcyc_u)) begin
      vif_u.vram_rdata = ret_u[vcyc_u];
      ret_u.delete(vcyc_u);
    end else begin
      vif_u.vram_rdata = $urandom;
    end
    vcyc_u++;
  end

  // Reference model state (for the READ_LATENCY = 2 instance)
  int          n_pass = 0, n_total = 0;
  int          tcyc = 0;
  bit          m_active = 1'b0;
  int          m_start = 0, m_row = 0, m_line = 0;
  bit          m_under = 1'b0;
  logic [31:0] mbuf [40];
  int          px = 0, py = 0, pline = 0, line_id = 0;
  bit          prst = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (x=%0d y=%0d)", name, act, exp, DrawX, DrawY);
  endtask

  function automatic bit trig_row(input int y, output int row);
    row = 0;
    if (y == 524) return 1'b1;
    if (y < 480 && (y % 16) == 15 && (y / 16 + 1) < 30) begin
      row = y / 16 + 1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_busy_at(input int t);
    return m_active && (t - m_start) >= 1 && (t - m_start) <= 40 + L;
  endfunction

  // One pixel cycle: advance the model over the edge, drive inputs, compare
  task automatic step(input int x, input int y, input bit rst);
    int  k, r, rel;
    bit  was_busy, exp_en, exp_busy;
    logic [31:0] exp_cp;
    @(posedge clk);
    if (prst) begin
      m_active = 1'b0;
      m_under  = 1'b0;
      for (int i = 0; i < 40; i++) mbuf[i] = 32'd0;
    end else begin
      was_busy = m_busy_at(tcyc);
      if (m_active) begin
        k = tcyc - m_start - 1 - L;
        if (k >= 0 && k < 40) mbuf[k] = 32'hA000_0000 + 32'(m_row * 40 + k);
        if (px == 799 && was_busy && pline == m_line) m_under = 1'b1;
        if (tcyc - m_start >= 40 + L) m_active = 1'b0;
      end
      if (px == 640 && !was_busy && trig_row(py, r)) begin
        m_active = 1'b1;
        m_start  = tcyc;
        m_row    = r;
        m_line   = pline;
      end
    end
    tcyc++;
    #1;
    DrawX = x[9:0];
    DrawY = y[9:0];
    reset = rst;
    #1;
    rel      = tcyc - m_start;
    exp_en   = m_active && rel >= 1 && rel <= 40;
    exp_busy = m_busy_at(tcyc);
    exp_cp   = (x < 640 && y < 480) ? mbuf[x / 16] : 32'd0;
    chk("vram_en", {31'd0, vif.vram_en}, {31'd0, exp_en});
    if (exp_en) chk("vram_addr", {21'd0, vif.vram_addr}, 32'(m_row * 40 + rel - 1));
    chk("fetch_busy", {31'd0, fetch_busy}, {31'd0, exp_busy});
    chk("underrun", {31'd0, underrun}, {31'd0, m_under});
    chk("cp_word", cp_word, exp_cp);
    px = x; py = y; prst = rst; pline = line_id;
  endtask

  typedef struct {
    int          x;
    int          y;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];
  int   en_cnt, en_cnt_u, ry, rx, sel;

  initial begin
    reset = 1'b1;
    DrawX = 10'd0;
    DrawY = 10'd0;

    for (int i = 0; i < 3; i++) step(0, 0, 1'b1);
    step(0, 0, 1'b0);
    chk("rst_vram_en", {31'd0, vif.vram_en}, 32'd0);
    chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_cp_word", cp_word, 32'd0);
    chk("rst_u_cp_word", cp_word_u, 32'd0);

    // Row 0 fetch on the last line of the frame
    line_id++;
    for (int x = 0; x < 800; x++) begin
      step(x, 524, 1'b0);
      if (x == 641) chk("r0_first_addr", {21'd0, vif.vram_addr}, 32'd0);
      if (x == 680) chk("r0_last_addr", {21'd0, vif.vram_addr}, 32'd39);
      if (x == 681) chk("r0_en_off", {31'd0, vif.vram_en}, 32'd0);
      if (x == 682) chk("r0_busy_682", {31'd0, fetch_busy}, 32'd1);
      if (x == 683) chk("r0_busy_683", {31'd0, fetch_busy}, 32'd0);
      if (x == 799) chk("u_busy_799", {31'd0, fetch_busy_u}, 32'd1);
      if (x == 799) chk("u_underrun_799", {31'd0, underrun_u}, 32'd0);
    end
    line_id++;
    for (int x = 0; x < 800; x++) begin
      step(x, 0, 1'b0);
      if (x == 0)   chk("u_underrun_set", {31'd0, underrun_u}, 32'd1);
      if (x == 20)  chk("u_busy_done", {31'd0, fetch_busy_u}, 32'd0);
      if (x == 100) chk("r0_cp_x100", cp_word, 32'hA000_0006);
      if (x == 630) chk("u_buf39", cp_word_u, 32'hA000_0027);
      if (x == 799) chk("u_underrun_sticky", {31'd0, underrun_u}, 32'd1);
    end

    // Lookup table against the row-0 buffer
    vecs[0]  = '{100, 0,   32'hA000_0006};
    vecs[1]  = '{0,   0,   32'hA000_0000};
    vecs[2]  = '{639, 0,   32'hA000_0027};
    vecs[3]  = '{640, 0,   32'h0000_0000};
    vecs[4]  = '{15,  15,  32'hA000_0000};
    vecs[5]  = '{16,  479, 32'hA000_0001};
    vecs[6]  = '{320, 200, 32'hA000_0014};
    vecs[7]  = '{100, 480, 32'h0000_0000};
    vecs[8]  = '{100, 524, 32'h0000_0000};
    vecs[9]  = '{799, 0,   32'h0000_0000};
    vecs[10] = '{639, 479, 32'hA000_0027};
    vecs[11] = '{32,  300, 32'hA000_0002};
    for (int i = 0; i < 12; i++) begin
      line_id++;
      step(vecs[i].x, vecs[i].y, 1'b0);
      chk("table_cp_word", cp_word, vecs[i].exp);
    end

    // Row 5 fetch triggered on line 79
    line_id++;
    for (int x = 0; x < 800; x++) begin
      step(x, 79, 1'b0);
      if (x == 641) chk("r5_first_addr", {21'd0, vif.vram_addr}, 32'd200);
      if (x == 680) chk("r5_last_addr", {21'd0, vif.vram_addr}, 32'd239);
    end
    line_id++;
    for (int x = 0; x < 64; x++) begin
      step(x, 80, 1'b0);
      if (x == 32) chk("r5_cp_x32", cp_word, 32'hA000_00CA);
    end

    // Lines that must not trigger
    for (int j = 0; j < 2; j++) begin
      ry = (j == 0) ? 479 : 40;
      line_id++;
      en_cnt = 0;
      en_cnt_u = 0;
      for (int x = 0; x < 800; x++) begin
        step(x, ry, 1'b0);
        if (vif.vram_en === 1'b1) en_cnt++;
        if (vif_u.vram_en === 1'b1) en_cnt_u++;
      end
      chk("notrig_en_count", 32'(en_cnt), 32'd0);
      chk("notrig_u_en_count", 32'(en_cnt_u), 32'd0);
    end

    // Reset pulse in the middle of the row-10 fetch
    line_id++;
    for (int x = 0; x < 800; x++) begin
      step(x, 159, x == 660);
      if (x == 661) chk("midrst_en", {31'd0, vif.vram_en}, 32'd0);
      if (x == 661) chk("midrst_busy", {31'd0, fetch_busy}, 32'd0);
    end
    line_id++;
    for (int x = 0; x < 800; x++) begin
      step(x, 160, 1'b0);
      if (x == 32)  chk("midrst_cp_x32", cp_word, 32'd0);
      if (x == 300) chk("midrst_cp_x300", cp_word, 32'd0);
    end

    // Randomized scanlines, biased toward row-final lines, with rare resets
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)       ry = 16 * $urandom_range(0, 29) + 15;
      else if (sel == 5) ry = 524;
      else               ry = $urandom_range(0, 524);
      rx = ($urandom_range(0, 7) == 0) ? $urandom_range(600, 720) : -1;
      line_id++;
      for (int x = 0; x < 800; x++) step(x, ry, x == rx);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
